// File: rtl/cart_download_ctrl.sv
// Cartridge download controller: packs the hps_io ioctl byte stream into memory words,
// routes them to an image slot, records image size/mirror mask and sequences core reset.
module cart_download_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_SLOTS   = 2,
  parameter int HOLD_CYCLES = 255,
  parameter int INDEX_BASE  = 1,
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ext_reset,
  output logic              mem_we,
  output logic [SLOT_W-1:0] mem_slot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              core_reset,
  output logic [NUM_SLOTS-1:0] loaded,
  output logic [24:0]       last_size,
  output logic [ADDR_W-1:0] mirror_mask,
  output logic              overflow
);

  localparam int BPW     = DATA_W / 8;
  localparam int LANE_SH = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_HOLD} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               armed;
  logic               load_start;
  logic [SLOT_W-1:0]  slot;
  logic               slot_ok;
  logic [DATA_W-1:0]  acc;
  logic               pend_valid;
  logic [ADDR_W-1:0]  pend_word;
  logic               flush_next;
  logic [24:0]        byte_count;

  logic [5:0]         idx6;
  logic [1:0]         index_unused;
  logic               idx_valid;
  logic [SLOT_W-1:0]  idx_slot;
  logic [24:0]        word_full;
  logic [ADDR_W-1:0]  word;
  logic               beyond_cap;
  logic [31:0]        lane;
  logic               last_lane;
  logic [DATA_W-1:0]  byte_shifted;
  logic [DATA_W-1:0]  merged;
  logic [24:0]        addr_plus;

  assign idx6         = ioctl_index[5:0];
  assign index_unused = ioctl_index[7:6];
  assign idx_valid    = (int'(idx6) >= INDEX_BASE) && (int'(idx6) < INDEX_BASE + NUM_SLOTS);
  assign idx_slot     = SLOT_W'(int'(idx6) - INDEX_BASE);
  assign word_full    = ioctl_addr >> LANE_SH;
  assign word         = word_full[ADDR_W-1:0];
  assign beyond_cap   = (word_full >> ADDR_W) != '0;
  assign lane         = 32'(ioctl_addr) % 32'(BPW);
  assign last_lane    = (lane == 32'(BPW - 1));
  assign byte_shifted = DATA_W'(ioctl_dout) << (lane * 8);
  assign merged       = acc | byte_shifted;
  assign addr_plus    = ioctl_addr + 25'd1;

  // A download only starts after ioctl_download has been seen low since reset,
  // so a reset in the middle of a transfer ignores the rest of that transfer.
  assign load_start = ioctl_download & armed;

  // Smallest all-ones mask covering the word count of an image of 'bytes' bytes.
  function automatic logic [ADDR_W-1:0] mask_for(input logic [24:0] bytes);
    logic [25:0] m;
    m = ((26'(bytes) + 26'(BPW - 1)) >> LANE_SH) - 26'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_next = S_LOAD;
        end else if (ext_reset) begin
          state_next = S_HOLD;
          cnt_next   = CNT_W'(HOLD_CYCLES);
        end
      end
      S_LOAD: begin
        if (!ioctl_download) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        state_next = S_HOLD;
        cnt_next   = CNT_W'(HOLD_CYCLES);
      end
      S_HOLD: begin
        if (load_start) begin
          state_next = S_LOAD;
        end else if (ext_reset) begin
          cnt_next = CNT_W'(HOLD_CYCLES);
        end else if (cnt == '0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = S_HOLD;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HOLD;
      cnt         <= CNT_W'(HOLD_CYCLES);
      core_reset  <= 1'b1;
      armed       <= 1'b0;
      mem_we      <= 1'b0;
      mem_slot    <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      loaded      <= '0;
      last_size   <= '0;
      mirror_mask <= '0;
      overflow    <= 1'b0;
      slot        <= '0;
      slot_ok     <= 1'b0;
      acc         <= '0;
      pend_valid  <= 1'b0;
      pend_word   <= '0;
      flush_next  <= 1'b0;
      byte_count  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      core_reset <= (state_next != S_IDLE) | ext_reset;
      armed      <= armed | ~ioctl_download;
      mem_we     <= 1'b0;
      if (state != S_LOAD && state_next == S_LOAD) begin
        slot       <= idx_slot;
        slot_ok    <= idx_valid;
        acc        <= '0;
        pend_valid <= 1'b0;
        flush_next <= 1'b0;
        byte_count <= '0;
        overflow   <= 1'b0;
        if (idx_valid) loaded[idx_slot] <= 1'b0;
      end else begin
        // Pending word goes out when completed behind a word change, or at end of load.
        if (flush_next || (state == S_FLUSH && pend_valid)) begin
          mem_we     <= 1'b1;
          mem_slot   <= slot;
          mem_addr   <= pend_word;
          mem_data   <= acc;
          acc        <= '0;
          pend_valid <= 1'b0;
          flush_next <= 1'b0;
        end
        if (state == S_LOAD && ioctl_wr && slot_ok) begin
          if (beyond_cap) begin
            overflow <= 1'b1;
          end else begin
            if (addr_plus > byte_count) byte_count <= addr_plus;
            if (pend_valid && word != pend_word) begin
              mem_we     <= 1'b1;
              mem_slot   <= slot;
              mem_addr   <= pend_word;
              mem_data   <= acc;
              acc        <= byte_shifted;
              pend_word  <= word;
              pend_valid <= 1'b1;
              flush_next <= last_lane;
            end else if (last_lane) begin
              mem_we     <= 1'b1;
              mem_slot   <= slot;
              mem_addr   <= word;
              mem_data   <= merged;
              acc        <= '0;
              pend_valid <= 1'b0;
            end else begin
              acc        <= merged;
              pend_word  <= word;
              pend_valid <= 1'b1;
            end
          end
        end
        if (state == S_FLUSH && slot_ok) begin
          if (byte_count != '0) begin
            loaded[slot] <= 1'b1;
            last_size    <= byte_count;
            mirror_mask  <= mask_for(byte_count);
          end else begin
            last_size    <= '0;
            mirror_mask  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cart_download_ctrl.sv
// Self-checking bench: four controller instances with different word/address widths share
// one ioctl stream; each is compared against a byte-level reference model of the download.
module tb_cart_download_ctrl;

  typedef struct {
    int     inst;
    int     slot;
    int     addr;
    longint data;
  } wr_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ext_reset;

  logic we0, we1, we2, we3;
  logic [0:0] slot0, slot1, slot2, slot3;
  logic [15:0] addr0, addr1;
  logic [3:0]  addr2;
  logic [7:0]  addr3;
  logic [7:0]  data0, data2;
  logic [15:0] data1;
  logic [31:0] data3;
  logic cr0, cr1, cr2, cr3;
  logic [1:0] loaded0, loaded1, loaded2, loaded3;
  logic [24:0] size0, size1, size2, size3;
  logic [15:0] mask0, mask1;
  logic [3:0]  mask2;
  logic [7:0]  mask3;
  logic ovf0, ovf1, ovf2, ovf3;

  cart_download_ctrl #(.ADDR_W(16), .DATA_W(8)) u_dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ext_reset(ext_reset), .mem_we(we0), .mem_slot(slot0),
    .mem_addr(addr0), .mem_data(data0), .core_reset(cr0), .loaded(loaded0),
    .last_size(size0), .mirror_mask(mask0), .overflow(ovf0));

  cart_download_ctrl #(.ADDR_W(16), .DATA_W(16)) u_dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ext_reset(ext_reset), .mem_we(we1), .mem_slot(slot1),
    .mem_addr(addr1), .mem_data(data1), .core_reset(cr1), .loaded(loaded1),
    .last_size(size1), .mirror_mask(mask1), .overflow(ovf1));

  cart_download_ctrl #(.ADDR_W(4), .DATA_W(8)) u_dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ext_reset(ext_reset), .mem_we(we2), .mem_slot(slot2),
    .mem_addr(addr2), .mem_data(data2), .core_reset(cr2), .loaded(loaded2),
    .last_size(size2), .mirror_mask(mask2), .overflow(ovf2));

  cart_download_ctrl #(.ADDR_W(8), .DATA_W(32)) u_dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ext_reset(ext_reset), .mem_we(we3), .mem_slot(slot3),
    .mem_addr(addr3), .mem_data(data3), .core_reset(cr3), .loaded(loaded3),
    .last_size(size3), .mirror_mask(mask3), .overflow(ovf3));

  int checks = 0;
  int fails  = 0;
  wr_t got[$];
  wr_t expq[$];
  int addr_q[$];
  int data_q[$];
  int bpw_of[4] = '{1, 2, 1, 4};
  int aw_of[4]  = '{16, 16, 4, 8};
  int     m_loaded[4];
  longint m_size[4];
  longint m_mask[4];
  int     m_ovf[4];

  // Capture every memory write away from the clock edge.
  always @(negedge clk_sys) begin
    if (we0 === 1'b1) got.push_back('{0, int'(slot0), int'(addr0), longint'(data0)});
    if (we1 === 1'b1) got.push_back('{1, int'(slot1), int'(addr1), longint'(data1)});
    if (we2 === 1'b1) got.push_back('{2, int'(slot2), int'(addr2), longint'(data2)});
    if (we3 === 1'b1) got.push_back('{3, int'(slot3), int'(addr3), longint'(data3)});
  end

  function automatic logic [63:0] wkey(input wr_t w);
    return (64'(w.slot) << 56) | (64'(w.addr) << 32) | 64'(w.data[31:0]);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: bytes grouped by word in arrival order; a group is written when its
  // top lane arrives, when the word changes, or at the end of the download.
  task automatic modelDownload(input logic [7:0] idx);
    bit valid;
    int slot;
    valid = (idx[5:0] >= 6'd1) && (idx[5:0] <= 6'd2);
    slot  = int'(idx[5:0]) - 1;
    for (int k = 0; k < 4; k++) begin
      int bpw, cap, gword, count, words, n, a, w, ln;
      longint gdata;
      bit gval;
      bpw = bpw_of[k];
      cap = bpw << aw_of[k];
      m_ovf[k] = 0;
      if (!valid) continue;
      m_loaded[k] &= ~(1 << slot);
      gval = 0; gdata = 0; gword = 0; count = 0;
      for (int j = 0; j < addr_q.size(); j++) begin
        a  = addr_q[j];
        w  = a / bpw;
        ln = a % bpw;
        if (a >= cap) begin
          m_ovf[k] = 1;
          continue;
        end
        if (gval && w != gword) begin
          expq.push_back('{k, slot, gword, gdata});
          gval = 0; gdata = 0;
        end
        gword = w; gval = 1;
        gdata |= longint'(data_q[j]) << (8 * ln);
        if (ln == bpw - 1) begin
          expq.push_back('{k, slot, gword, gdata});
          gval = 0; gdata = 0;
        end
        if (a + 1 > count) count = a + 1;
      end
      if (gval) expq.push_back('{k, slot, gword, gdata});
      if (count > 0) begin
        m_loaded[k] |= (1 << slot);
        m_size[k] = count;
        words = (count + bpw - 1) / bpw;
        n = 0;
        while ((1 << n) < words) n++;
        m_mask[k] = (longint'(1) << n) - 1;
      end else begin
        m_size[k] = 0;
        m_mask[k] = 0;
      end
    end
  endtask

  task automatic checkState();
    for (int k = 0; k < 4; k++) begin
      logic [63:0] ld, sz, mk, ov, cr;
      ld = '0; sz = '0; mk = '0; ov = '0; cr = '0;
      case (k)
        0: begin ld = 64'(loaded0); sz = 64'(size0); mk = 64'(mask0); ov = 64'(ovf0); cr = 64'(cr0); end
        1: begin ld = 64'(loaded1); sz = 64'(size1); mk = 64'(mask1); ov = 64'(ovf1); cr = 64'(cr1); end
        2: begin ld = 64'(loaded2); sz = 64'(size2); mk = 64'(mask2); ov = 64'(ovf2); cr = 64'(cr2); end
        default: begin ld = 64'(loaded3); sz = 64'(size3); mk = 64'(mask3); ov = 64'(ovf3); cr = 64'(cr3); end
      endcase
      checkOutput($sformatf("inst%0d_loaded", k), ld, 64'(m_loaded[k]));
      checkOutput($sformatf("inst%0d_last_size", k), sz, 64'(m_size[k]));
      checkOutput($sformatf("inst%0d_mirror_mask", k), mk, 64'(m_mask[k]));
      checkOutput($sformatf("inst%0d_overflow", k), ov, 64'(m_ovf[k]));
      checkOutput($sformatf("inst%0d_core_reset_idle", k), cr, 64'd0);
    end
  endtask

  task automatic checkWrites();
    for (int k = 0; k < 4; k++) begin
      wr_t g[$];
      wr_t e[$];
      foreach (got[i]) if (got[i].inst == k) g.push_back(got[i]);
      foreach (expq[i]) if (expq[i].inst == k) e.push_back(expq[i]);
      checkOutput($sformatf("inst%0d_wr_count", k), 64'(g.size()), 64'(e.size()));
      for (int i = 0; i < g.size() && i < e.size(); i++)
        checkOutput($sformatf("inst%0d_wr%0d", k, i), wkey(g[i]), wkey(e[i]));
    end
    got.delete();
    expq.delete();
  endtask

  task automatic waitIdle(output int hc);
    hc = 0;
    while (cr0 !== 1'b0 && hc < 400) begin
      @(posedge clk_sys); #1;
      hc++;
    end
    checkOutput("idle_reached", 64'(cr0), 64'd0);
  endtask

  task automatic startDownload(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    checkOutput("core_reset_in_load", 64'(cr0), 64'd1);
  endtask

  task automatic sendBytes(input int lo, input int hi);
    for (int j = lo; j < hi; j++) begin
      ioctl_addr = 25'(addr_q[j]);
      ioctl_dout = 8'(data_q[j]);
      ioctl_wr = 1'b1;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] idx);
    int hc;
    startDownload(idx);
    sendBytes(0, addr_q.size());
    ioctl_download = 1'b0;
    modelDownload(idx);
    waitIdle(hc);
    checkOutput("hold_after_download", 64'(hc >= 255 && hc <= 262), 64'd1);
    checkState();
    checkWrites();
  endtask

  initial begin
    int hc;
    int nxt;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ext_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_loaded[k] = 0; m_size[k] = 0; m_mask[k] = 0; m_ovf[k] = 0;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_core_reset", 64'(cr0), 64'd1);
    checkOutput("rst_mem_we", 64'(we0), 64'd0);
    checkOutput("rst_mem_addr", 64'(addr0), 64'd0);
    checkOutput("rst_mem_data", 64'(data3), 64'd0);
    checkOutput("rst_loaded", 64'(loaded1), 64'd0);
    checkOutput("rst_last_size", 64'(size0), 64'd0);
    checkOutput("rst_mirror_mask", 64'(mask0), 64'd0);
    checkOutput("rst_overflow", 64'(ovf2), 64'd0);
    reset_n = 1'b1;
    waitIdle(hc);

    $display("[TB] 4096-byte sequential image to slot 0");
    addr_q.delete(); data_q.delete();
    for (int i = 0; i < 4096; i++) begin
      addr_q.push_back(i);
      data_q.push_back(int'($urandom_range(0, 255)));
    end
    applyStimulus(8'd1);

    $display("[TB] three-byte image, partial final word");
    addr_q = '{0, 1, 2};
    data_q = '{'hAA, 'hBB, 'hCC};
    applyStimulus(8'd1);

    $display("[TB] slot 1 image of 0x3000 bytes");
    addr_q = '{'h2FFF};
    data_q = '{int'($urandom_range(0, 255))};
    applyStimulus(8'd2);

    $display("[TB] out-of-range index");
    addr_q = '{0, 1, 2, 3, 4};
    data_q = '{1, 2, 3, 4, 5};
    applyStimulus(8'd5);

    $display("[TB] randomized address patterns");
    for (int r = 0; r < 4; r++) begin
      addr_q.delete(); data_q.delete();
      nxt = 0;
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 1) == 0) nxt = int'($urandom_range(0, 47));
        addr_q.push_back(nxt);
        data_q.push_back(int'($urandom_range(0, 255)));
        nxt = nxt + 1;
      end
      applyStimulus(8'(1 + $urandom_range(0, 1)));
    end

    $display("[TB] ext_reset pulse in idle");
    checkOutput("ext_cr_before", 64'(cr0), 64'd0);
    ext_reset = 1'b1;
    @(posedge clk_sys); #1;
    checkOutput("ext_cr_rise", 64'(cr0), 64'd1);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    ext_reset = 1'b0;
    waitIdle(hc);
    checkOutput("ext_hold_len", 64'(3 + hc - 1), 64'd258);
    checkState();

    $display("[TB] reset in the middle of a download");
    addr_q.delete(); data_q.delete();
    for (int i = 0; i < 120; i++) begin
      addr_q.push_back(i);
      data_q.push_back(int'($urandom_range(0, 255)));
    end
    startDownload(8'd1);
    sendBytes(0, 100);
    reset_n = 1'b0;
    #2;
    checkOutput("midrst_loaded", 64'(loaded0), 64'd0);
    checkOutput("midrst_core_reset", 64'(cr0), 64'd1);
    checkOutput("midrst_last_size", 64'(size0), 64'd0);
    got.delete();
    expq.delete();
    for (int k = 0; k < 4; k++) begin
      m_loaded[k] = 0; m_size[k] = 0; m_mask[k] = 0; m_ovf[k] = 0;
    end
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    sendBytes(100, 120);
    ioctl_download = 1'b0;
    waitIdle(hc);
    checkOutput("midrst_no_writes", 64'(got.size()), 64'd0);
    checkState();

    $display("[TB] recovery download");
    addr_q.delete(); data_q.delete();
    for (int i = 0; i < 25; i++) begin
      addr_q.push_back(i);
      data_q.push_back(int'($urandom_range(0, 255)));
    end
    applyStimulus(8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
